// File: rtl/router_pkt_src_if.sv
// Host and router signal bundle for router_pkt_src.
//   slave  : view taken by router_pkt_src (consumes requests/payload and
//            busy/err, drives the router side and status)
//   master : view taken by the environment (host plus router) that drives
//            requests, payload bytes, busy and err
// Signals:
//   req_valid/req_addr/req_len/req_bad_par -> request in; req_ready/req_rej out
//   pl_valid/pl_data -> payload in; pl_ready out
//   busy/err -> router status in; packet_valid/datain -> router data out
//   pkt_done/err_flag/pkt_cnt -> completion status out
interface router_pkt_src_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic [1:0]       req_addr;
  logic [5:0]       req_len;
  logic             req_bad_par;
  logic             req_ready;
  logic             req_rej;
  logic             pl_valid;
  logic [7:0]       pl_data;
  logic             pl_ready;
  logic             busy;
  logic             err;
  logic             packet_valid;
  logic [7:0]       datain;
  logic             pkt_done;
  logic             err_flag;
  logic [CNT_W-1:0] pkt_cnt;

  modport slave (
    input  req_valid, req_addr, req_len, req_bad_par, pl_valid, pl_data, busy, err,
    output req_ready, req_rej, pl_ready, packet_valid, datain, pkt_done, err_flag, pkt_cnt
  );

  modport master (
    output req_valid, req_addr, req_len, req_bad_par, pl_valid, pl_data, busy, err,
    input  req_ready, req_rej, pl_ready, packet_valid, datain, pkt_done, err_flag, pkt_cnt
  );
endinterface

// File: rtl/router_pkt_src.sv
// Upstream packet source for the 1x3 router.
// Accepts a host request (destination + length), buffers the whole payload,
// then sends header, payload and parity as one contiguous packet so that
// packet_valid never drops mid-payload. Stalls while the router is busy and
// records router parity errors seen during the inter-frame gap.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : router_pkt_src_if.slave (request, payload, router and status signals)
// Parameters:
//   MAX_LEN : largest accepted payload length (<=63), buffer depth
//   IFG     : idle cycles after parity before the next request (>=1)
//   CNT_W   : width of pkt_cnt (must match the interface CNT_W)
module router_pkt_src #(
  parameter int MAX_LEN = 63,
  parameter int IFG     = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  router_pkt_src_if.slave    bus
);

  localparam int         GAP_W     = (IFG < 2) ? 1 : $clog2(IFG);
  localparam logic [6:0] MAX_LEN_C = 7'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [1:0]       r_addr;
  logic [5:0]       r_len;
  logic             r_bad_par;
  logic [5:0]       r_wr_ptr;
  logic [5:0]       r_rd_ptr;
  logic [7:0]       r_parity;
  logic [GAP_W-1:0] r_gap;
  logic             r_packet_valid;
  logic [7:0]       r_datain;
  logic             r_req_rej;
  logic             r_pkt_done;
  logic             r_err_flag;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [7:0]       r_buf [MAX_LEN];

  logic       w_req_ready;
  logic       w_pl_ready;
  logic       w_req_fire;
  logic       w_pl_fire;
  logic       w_req_legal;
  logic       w_last_wr;
  logic       w_last_rd;
  logic [5:0] w_rd_next;
  logic [7:0] w_hdr;
  logic [7:0] w_par_mask;

  // Handshake readies decode straight from the registered state.
  assign w_req_ready = (r_state == S_IDLE);
  assign w_pl_ready  = (r_state == S_LOAD);
  assign w_req_fire  = bus.req_valid & w_req_ready;
  assign w_pl_fire   = bus.pl_valid & w_pl_ready;
  assign w_req_legal = (bus.req_addr != 2'd3) && (bus.req_len != 6'd0) &&
                       ({1'b0, bus.req_len} <= MAX_LEN_C);
  assign w_last_wr   = (r_wr_ptr == r_len - 6'd1);
  assign w_last_rd   = (r_rd_ptr == r_len - 6'd1);
  assign w_rd_next   = r_rd_ptr + 6'd1;
  assign w_hdr       = {r_len, r_addr};
  assign w_par_mask  = r_bad_par ? 8'hFF : 8'h00;

  // Payload buffer: data only, contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_pl_fire) begin
      r_buf[r_wr_ptr] <= bus.pl_data;
    end
  end

  // Control FSM. datain always holds the byte currently offered to the
  // router, so a busy stall simply means "change nothing".
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_len          <= '0;
      r_bad_par      <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_parity       <= '0;
      r_gap          <= '0;
      r_packet_valid <= 1'b0;
      r_datain       <= '0;
      r_req_rej      <= 1'b0;
      r_pkt_done     <= 1'b0;
      r_err_flag     <= 1'b0;
      r_pkt_cnt      <= '0;
    end else begin
      r_req_rej  <= 1'b0;
      r_pkt_done <= 1'b0;
      if ((r_state == S_GAP) && bus.err) begin
        r_err_flag <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            if (w_req_legal) begin
              r_addr    <= bus.req_addr;
              r_len     <= bus.req_len;
              r_bad_par <= bus.req_bad_par;
              r_wr_ptr  <= '0;
              r_rd_ptr  <= '0;
              r_state   <= S_LOAD;
            end else begin
              r_req_rej <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_pl_fire) begin
            r_wr_ptr <= r_wr_ptr + 6'd1;
            if (w_last_wr) begin
              r_packet_valid <= 1'b1;
              r_datain       <= w_hdr;
              r_state        <= S_HEADER;
            end
          end
        end
        S_HEADER: begin
          if (!bus.busy) begin
            r_parity <= w_hdr;
            r_datain <= r_buf[6'd0];
            r_rd_ptr <= '0;
            r_state  <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!bus.busy) begin
            r_parity <= r_parity ^ r_datain;
            if (w_last_rd) begin
              // Final byte leaves now; present the (optionally inverted) parity.
              r_packet_valid <= 1'b0;
              r_datain       <= r_parity ^ r_datain ^ w_par_mask;
              r_state        <= S_PARITY;
            end else begin
              r_rd_ptr <= w_rd_next;
              r_datain <= r_buf[w_rd_next];
            end
          end
        end
        S_PARITY: begin
          if (!bus.busy) begin
            r_gap   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_W'(IFG - 1)) begin
            r_pkt_done <= 1'b1;
            r_pkt_cnt  <= r_pkt_cnt + 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.pl_ready     = w_pl_ready;
  assign bus.req_rej      = r_req_rej;
  assign bus.packet_valid = r_packet_valid;
  assign bus.datain       = r_datain;
  assign bus.pkt_done     = r_pkt_done;
  assign bus.err_flag     = r_err_flag;
  assign bus.pkt_cnt      = r_pkt_cnt;

endmodule
